// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states
// and the mux-select / ALU-class codes driven onto the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SHL = 2'b11;

  // A zero timeout still needs a one-bit counter so the ports stay legal.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles spent in a memory state and flags the
// cycle on which the next stall would exceed MEM_TIMEOUT.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mem_state,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int CW = wait_cnt_w(MEM_TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          w_stall;

  assign w_stall = i_mem_state && !i_mem_ready;

  // Any cycle that is not a stall clears the count, so every entry into a
  // memory state starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_stall) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign o_timeout = 1'b0;
    end else begin : g_timeout
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
      assign o_timeout = w_stall && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: registered state, datapath controls decoded
// from the state, with a memory-stall watchdog that traps into ERROR.
module multi_cycle_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] Opcode,
  input  logic       Mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State,
  output logic       Inst_done,
  output logic       Illegal_op,
  output logic       Error
);

  state_t r_state;
  logic   w_timeout;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_clk      (CLK),
    .i_reset    (RESET),
    .i_mem_state(is_mem_state(r_state)),
    .i_mem_ready(Mem_ready),
    .o_timeout  (w_timeout)
  );

  // Mem_ready is tested before the timeout so a completion on the last
  // allowed cycle still retires normally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (Mem_ready) r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_ERROR;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDI_EX;
            default:      r_state <= ILLEGAL_TRAP ? S_ERROR : S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (Mem_ready) r_state <= S_MEMWB;
                    else if (w_timeout) r_state <= S_ERROR;
        S_MEMWRITE: if (Mem_ready) r_state <= S_FETCH;
                    else if (w_timeout) r_state <= S_ERROR;
        S_EXECUTE:  r_state <= S_RTYPE_WB;
        S_ADDI_EX:  r_state <= S_ADDI_WB;
        S_ERROR:    r_state <= S_ERROR;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = ALUB_REG;
    Inst_done   = 1'b0;
    Illegal_op  = 1'b0;
    Error       = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUB_FOUR;
        PCWrite = Mem_ready;
        IRWrite = Mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = ALUB_IMM_SHL;
        Illegal_op = !is_legal_op(Opcode);
      end
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUB_IMM;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        Inst_done = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        Inst_done = Mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        Inst_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        Inst_done   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = PCSRC_JUMP;
        Inst_done = 1'b1;
      end
      S_ADDI_WB: begin
        RegWrite  = 1'b1;
        Inst_done = 1'b1;
      end
      S_ERROR: Error = 1'b1;
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, 15, max consecutive not-ready cycles in a memory state before ERROR (0 disables timeout).
REQ-002 Parameter ILLEGAL_TRAP, 0, 1: illegal opcode enters ERROR; 0: illegal opcode returns to FETCH.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 Opcode  in  6  Instruction[31:26] from instruction register.
REQ-007 Mem_ready  in  1  memory has completed the current read/write this cycle.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  standard multi-cycle MIPS datapath controls.
REQ-009 PCSource, ALUOp, ALUSrcB  out  2 each  mux selects / ALU op class (ALUOp 00 add, 01 sub, 10 funct).
REQ-010 State  out  4  current state encoding; Inst_done  out  1  instruction retires this cycle; Illegal_op  out  1  one-cycle pulse; Error  out  1  sticky fault.

Function
REQ-011 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RTYPE_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, ERROR 12; encodings 13-15 go to FETCH.
REQ-012 All outputs are decoded from State only, except PCWrite/IRWrite in FETCH and Inst_done in MEMWRITE, which are gated by Mem_ready; unlisted outputs are 0.
REQ-013 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=IRWrite=Mem_ready; Mem_ready=1 -> DECODE, else stay.
REQ-014 DECODE: ALUSrcB=11, ALUOp=00; Opcode 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDI_EX; any other -> Illegal_op=1, next FETCH (ILLEGAL_TRAP=0) or ERROR (ILLEGAL_TRAP=1).
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEMREAD, sw -> MEMWRITE.
REQ-016 MEMREAD: MemRead=1, IorD=1; Mem_ready=1 -> MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, Inst_done=1 -> FETCH.
REQ-017 MEMWRITE: MemWrite=1, IorD=1; Mem_ready=1 -> FETCH with Inst_done=1 that cycle.
REQ-018 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPE_WB; RTYPE_WB: RegWrite=1, RegDst=1, Inst_done=1 -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Inst_done=1 -> FETCH; JUMP: PCWrite=1, PCSource=10, Inst_done=1 -> FETCH.
REQ-020 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB; ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, Inst_done=1 -> FETCH.
REQ-021 Wait counter, width clog2(MEM_TIMEOUT+1): cleared on entry to FETCH/MEMREAD/MEMWRITE, +1 each cycle in those states with Mem_ready=0, saturating.
REQ-022 Timeout: in a memory state with Mem_ready=0 and counter = MEM_TIMEOUT-1 (MEM_TIMEOUT>0) -> next ERROR; Mem_ready=1 in the same cycle wins.
REQ-023 ERROR: all datapath controls 0, Error=1, held until RESET.
REQ-024 Latencies with Mem_ready=1: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3; each wait cycle adds 1.

Reset
REQ-025 RESET=1 at a rising edge: State=FETCH, counter=0, Error=0, Illegal_op=0, regardless of current state, including mid MEMWRITE/MEMREAD.
REQ-026 RESET has priority over every transition; first cycle after reset presents FETCH outputs.

Structure
REQ-027 Package mips_pkg holds opcode constants, state encodings, ALUOp/PCSource/ALUSrcB encodings.
REQ-028 One sub-module mem_wait_timer (counter + timeout compare, parameter MEM_TIMEOUT); next-state and output decode stay in multi_cycle_control.

Verification
REQ-029 Opcode 000000, Mem_ready=1 -> states 0,1,6,7,0; Inst_done=1 with RegDst=1, RegWrite=1 in cycle 4.
REQ-030 Opcode 100011, Mem_ready=0 for 3 cycles in MEMREAD -> MemRead=1, IorD=1 held 4 cycles; MEMWB in cycle 8, MemtoReg=1.
REQ-031 MEM_TIMEOUT=4, Mem_ready=0 in FETCH -> State=12, Error=1 after 4 cycles; stays until RESET, then State=0.
REQ-032 Opcode 111111, ILLEGAL_TRAP=0 -> Illegal_op=1 for one cycle in DECODE, no RegWrite/MemWrite/PCWrite, back to FETCH; ILLEGAL_TRAP=1 -> State=12.
REQ-033 Opcode 000100 -> BRANCH cycle with PCWriteCond=1, PCSource=01, ALUOp=01; opcode 000010 -> PCWrite=1, PCSource=10.
REQ-034 RESET asserted during MEMWRITE with Mem_ready=0 -> next cycle State=0, MemWrite=0, counter=0.
